// File: rtl/ev20_branch_pkg.sv
// Shared definitions for the MicroEV20 conditional-jump speculation path.
package ev20_branch_pkg;

  localparam int unsigned PC_W = 11;

  typedef logic [1:0] btype_t;

  localparam btype_t TYPE_NONE = 2'b00;
  localparam btype_t TYPE_JZE  = 2'b01;
  localparam btype_t TYPE_JNE  = 2'b10;
  localparam btype_t TYPE_JCY  = 2'b11;

  // Weak not-taken.
  localparam logic [1:0] CNT_INIT = 2'b01;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } ctrl_state_t;

  // Outstanding-branch queue entry; the predictor index is kept alongside
  // in the controller because its width follows TBL_BITS.
  typedef struct packed {
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    btype_t          btype;
    logic            pred;
  } q_entry_t;

endpackage

// File: rtl/pred_counter_table.sv
// 2^TBL_BITS two-bit saturating counters.
//   rd_idx / rd_taken : asynchronous read, returns the counter MSB
//   upd_en / upd_idx / upd_taken : synchronous train (+1 taken, -1 not taken)
module pred_counter_table
  import ev20_branch_pkg::*;
#(
  parameter int unsigned TBL_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TBL_BITS-1:0] rd_idx,
  output logic                rd_taken,
  input  logic                upd_en,
  input  logic [TBL_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int unsigned N = 1 << TBL_BITS;

  logic [1:0] cnt [N];

  assign rd_taken = cnt[rd_idx][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        cnt[i] <= CNT_INIT;
      end
    end else if (upd_en) begin
      if (upd_taken) begin
        if (cnt[upd_idx] != 2'b11) cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
      end else begin
        if (cnt[upd_idx] != 2'b00) cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_spec_ctrl.sv
// Branch speculation controller: predicts issued conditional jumps, queues
// outstanding predictions in order, trains on resolution and sequences a
// flush/redirect on a misprediction.
//   issue_*    : fetch-side branch issue, issue_ready / pred_taken back
//   head_*     : oldest outstanding prediction to the checker
//   res_*      : checker resolution of the oldest branch
//   flush, redirect_* : registered one-cycle squash/redirect
//   underflow  : sticky, resolution arrived with an empty queue
module branch_spec_ctrl
  import ev20_branch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TBL_BITS  = 4,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [10:0] issue_pc,
  input  logic [10:0] issue_target,
  input  logic [1:0]  issue_type,
  output logic        issue_ready,
  output logic        pred_taken,
  output logic        head_valid,
  output logic        head_pred,
  output logic [1:0]  head_type,
  input  logic        res_valid,
  input  logic        res_incorrect,
  input  logic        res_taken,
  output logic        flush,
  output logic        redirect_valid,
  output logic [10:0] redirect_addr,
  output logic        underflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ctrl_state_t         state, state_nxt;
  logic [FW-1:0]       fcnt, fcnt_nxt;
  q_entry_t            q_mem [DEPTH];
  logic [TBL_BITS-1:0] q_idx [DEPTH];
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic                q_empty;
  logic                res_take, mispred, push, pop;
  q_entry_t            head, new_entry;

  pred_counter_table #(
    .TBL_BITS(TBL_BITS)
  ) u_tbl (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (issue_pc[TBL_BITS-1:0]),
    .rd_taken (pred_taken),
    .upd_en   (pop),
    .upd_idx  (q_idx[rd_ptr]),
    .upd_taken(res_taken)
  );

  assign q_empty = (count == '0);
  assign head    = q_mem[rd_ptr];

  always_comb begin
    res_take    = (state == ST_RUN) & res_valid & !q_empty;
    mispred     = res_take & res_incorrect;
    issue_ready = (state == ST_RUN) & ((count < FULL) | res_valid)
                  & !(res_valid & res_incorrect);
    push        = issue_valid & issue_ready & (issue_type != TYPE_NONE);
    pop         = res_take;
  end

  always_comb begin
    new_entry        = '0;
    new_entry.pc_inc = issue_pc + 11'd1;
    new_entry.target = issue_target;
    new_entry.btype  = issue_type;
    new_entry.pred   = pred_taken;
  end

  always_comb begin
    head_valid = !q_empty;
    head_pred  = head_valid ? head.pred  : 1'b0;
    head_type  = head_valid ? head.btype : TYPE_NONE;
  end

  // The countdown is held while the registered flush pulse is out, so the
  // redirect cycle is not counted toward the FLUSH_CYC stall cycles.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      ST_RUN: begin
        if (mispred) begin
          state_nxt = ST_FLUSH;
          fcnt_nxt  = FW'(FLUSH_CYC - 1);
        end
      end
      ST_FLUSH: begin
        if (!flush) begin
          if (fcnt == '0) state_nxt = ST_RUN;
          else            fcnt_nxt  = fcnt - FW'(1);
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      fcnt           <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      underflow      <= 1'b0;
    end else begin
      state          <= state_nxt;
      fcnt           <= fcnt_nxt;
      flush          <= mispred;
      redirect_valid <= mispred;
      if (mispred) begin
        redirect_addr <= res_taken ? head.target : head.pc_inc;
      end
      if ((state == ST_RUN) && res_valid && q_empty) begin
        underflow <= 1'b1;
      end
      if (mispred) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_mem[wr_ptr] <= new_entry;
      q_idx[wr_ptr] <= issue_pc[TBL_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_branch_spec_ctrl.sv
module tb_branch_spec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [10:0] issue_pc;
  logic [10:0] issue_target;
  logic [1:0]  issue_type;
  logic        issue_ready;
  logic        pred_taken;
  logic        head_valid;
  logic        head_pred;
  logic [1:0]  head_type;
  logic        res_valid;
  logic        res_incorrect;
  logic        res_taken;
  logic        flush;
  logic        redirect_valid;
  logic [10:0] redirect_addr;
  logic        underflow;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  branch_spec_ctrl #(
    .DEPTH    (4),
    .TBL_BITS (4),
    .FLUSH_CYC(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_pc      (issue_pc),
    .issue_target  (issue_target),
    .issue_type    (issue_type),
    .issue_ready   (issue_ready),
    .pred_taken    (pred_taken),
    .head_valid    (head_valid),
    .head_pred     (head_pred),
    .head_type     (head_type),
    .res_valid     (res_valid),
    .res_incorrect (res_incorrect),
    .res_taken     (res_taken),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .underflow     (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    issue_valid   = 1'b0;
    issue_pc      = '0;
    issue_target  = '0;
    issue_type    = 2'b00;
    res_valid     = 1'b0;
    res_incorrect = 1'b0;
    res_taken     = 1'b0;
  endtask

  task automatic put(input logic [10:0] pc, input logic [10:0] tgt, input logic [1:0] ty);
    issue_valid  = 1'b1;
    issue_pc     = pc;
    issue_target = tgt;
    issue_type   = ty;
  endtask

  task automatic res(input logic inc, input logic tk);
    res_valid     = 1'b1;
    res_incorrect = inc;
    res_taken     = tk;
  endtask

  logic [1:0] fill_ty [4];
  logic [1:0] drain_ty [4];

  initial begin
    fill_ty  = '{2'b01, 2'b10, 2'b11, 2'b01};
    drain_ty = '{2'b10, 2'b11, 2'b01, 2'b10};

    // reset
    quiet();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_head_valid", head_valid, 0);
    chk("rst_head_pred", head_pred, 0);
    chk("rst_head_type", head_type, 0);
    chk("rst_flush", flush, 0);
    chk("rst_redir_valid", redirect_valid, 0);
    chk("rst_redir_addr", redirect_addr, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_ready", issue_ready, 1);
    rst_n = 1'b1;

    // first issue, counter idx0 = 01
    put(11'h010, 11'h050, 2'b01);
    #1;
    chk("pred_init", pred_taken, 0);
    chk("ready_empty", issue_ready, 1);
    tick();
    quiet();
    chk("push_head_valid", head_valid, 1);
    chk("push_head_type", head_type, 1);
    chk("push_head_pred", head_pred, 0);

    // train idx0 taken three times: 01 -> 10 -> 11 -> 11
    res(0, 1);
    tick();
    quiet();
    chk("pop_empty", head_valid, 0);
    put(11'h010, 11'h050, 2'b01);
    #1;
    chk("pred_cnt10", pred_taken, 1);
    tick();
    quiet();
    chk("head_pred_cnt10", head_pred, 1);
    res(0, 1);
    tick();
    quiet();
    put(11'h010, 11'h050, 2'b01);
    #1;
    chk("pred_cnt11", pred_taken, 1);
    tick();
    quiet();
    res(0, 1);
    tick();
    quiet();
    put(11'h010, 11'h050, 2'b01);
    #1;
    chk("pred_saturated", pred_taken, 1);
    tick();
    quiet();
    res(0, 0);          // idx0 -> 10
    tick();
    quiet();

    // same-cycle issue to the index being trained sees the old counter
    put(11'h021, 11'h060, 2'b10);
    #1;
    chk("pred_idx1", pred_taken, 0);
    tick();
    quiet();
    res(0, 1);
    put(11'h021, 11'h060, 2'b10);
    #1;
    chk("pred_same_cycle_old", pred_taken, 0);
    chk("ready_res_empty_q", issue_ready, 1);
    tick();
    quiet();
    chk("same_head_valid", head_valid, 1);
    chk("same_head_pred", head_pred, 0);
    chk("same_head_type", head_type, 2);
    res(0, 0);          // idx1 -> 01
    tick();
    quiet();
    chk("same_drained", head_valid, 0);

    // fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      put(11'h100 + 11'(i), 11'h180 + 11'(i), fill_ty[i]);
      tick();
    end
    quiet();
    #1;
    chk("ready_full", issue_ready, 0);
    chk("full_head_type", head_type, 1);
    put(11'h1FF, 11'h000, 2'b11);   // rejected while full
    tick();
    quiet();
    res(0, 0);
    put(11'h104, 11'h184, 2'b10);
    #1;
    chk("ready_full_pop", issue_ready, 1);
    tick();
    quiet();
    #1;
    chk("full_after_swap", issue_ready, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", head_valid, 1);
      chk("drain_type", head_type, drain_ty[i]);
      res(0, 0);
      tick();
      quiet();
    end
    chk("drain_empty", head_valid, 0);

    // mispredict, taken -> target; idx0 is 01 here
    put(11'h040, 11'h123, 2'b11);
    #1;
    chk("pred_040", pred_taken, 0);
    tick();
    put(11'h050, 11'h077, 2'b01);
    tick();
    quiet();
    chk("mp_head_pred", head_pred, 0);
    chk("mp_head_type", head_type, 3);
    res(1, 1);
    put(11'h060, 11'h0AA, 2'b10);
    #1;
    chk("ready_mispred", issue_ready, 0);
    tick();
    chk("mp_flush", flush, 1);
    chk("mp_redir_valid", redirect_valid, 1);
    chk("mp_redir_addr", redirect_addr, 11'h123);
    chk("mp_q_cleared", head_valid, 0);
    res(0, 0);          // ignored while flushing
    #1;
    chk("ready_fl0", issue_ready, 0);
    tick();
    chk("fl1_flush", flush, 0);
    chk("fl1_redir_valid", redirect_valid, 0);
    chk("fl1_head_valid", head_valid, 0);
    chk("ready_fl1", issue_ready, 0);
    tick();
    chk("fl2_underflow", underflow, 0);
    chk("fl2_head_valid", head_valid, 0);
    chk("ready_fl2", issue_ready, 0);
    quiet();
    tick();
    chk("ready_back", issue_ready, 1);
    chk("back_head_valid", head_valid, 0);

    // pc 0x7FF wrap on not-taken redirect
    put(11'h7FF, 11'h200, 2'b01);
    #1;
    chk("pred_7ff_init", pred_taken, 0);
    tick();
    quiet();
    res(0, 1);          // idxF -> 10
    tick();
    quiet();
    put(11'h7FF, 11'h200, 2'b10);
    #1;
    chk("pred_7ff_trained", pred_taken, 1);
    tick();
    quiet();
    chk("wrap_head_pred", head_pred, 1);
    res(1, 0);
    tick();
    quiet();
    chk("wrap_flush", flush, 1);
    chk("wrap_redir_valid", redirect_valid, 1);
    chk("wrap_redir_addr", redirect_addr, 11'h000);
    tick();
    tick();
    tick();
    chk("wrap_ready_back", issue_ready, 1);

    // underflow, sticky, no flush
    res(1, 0);
    tick();
    quiet();
    chk("uf_set", underflow, 1);
    chk("uf_no_flush", flush, 0);
    chk("uf_no_redir", redirect_valid, 0);
    tick();
    tick();
    chk("uf_sticky", underflow, 1);

    // idx0 is 10 (trained taken by the 0x040 redirect)
    put(11'h300, 11'h3AB, 2'b11);
    #1;
    chk("pred_300", pred_taken, 1);
    tick();
    quiet();
    res(1, 1);          // idx0 -> 11
    tick();
    quiet();
    chk("rf_flush", flush, 1);
    chk("rf_redir_addr", redirect_addr, 11'h3AB);
    rst_n = 1'b0;
    tick();
    chk("rf_head_valid", head_valid, 0);
    chk("rf_head_pred", head_pred, 0);
    chk("rf_head_type", head_type, 0);
    chk("rf_flush_clr", flush, 0);
    chk("rf_redir_valid", redirect_valid, 0);
    chk("rf_redir_addr_clr", redirect_addr, 0);
    chk("rf_underflow_clr", underflow, 0);
    chk("rf_ready", issue_ready, 1);
    rst_n = 1'b1;
    put(11'h300, 11'h3AB, 2'b11);
    #1;
    chk("pred_after_rst", pred_taken, 0);
    tick();
    quiet();
    chk("post_rst_head_valid", head_valid, 1);
    chk("post_rst_head_pred", head_pred, 0);
    chk("post_rst_head_type", head_type, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_spec_ctrl.md
# branch_spec_ctrl

Speculation controller for the MicroEV20 conditional-jump path (JZE, JNE, JCY). It predicts each issued branch with a table of 2-bit saturating counters and queues the outstanding predictions in order. It feeds the oldest prediction and its type to the prediction checker. When the checker resolves a branch, the block trains the table and, on a misprediction, squashes the queue and sequences a flush-and-redirect of the micro-PC.

## Interface
- DEPTH, 4: outstanding-branch queue entries (power of 2, ≥2)
- TBL_BITS, 4: predictor index width; table has 2^TBL_BITS counters
- FLUSH_CYC, 2: cycles `issue_ready` stays low after a redirect (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- issue_valid  in  1  a conditional jump is being fetched
- issue_pc  in  11  address of the jump
- issue_target  in  11  jump target (P field)
- issue_type  in  2  01 JZE, 10 JNE, 11 JCY; 00 is illegal and is ignored
- issue_ready  out  1  issue accepted this cycle
- pred_taken  out  1  prediction for `issue_pc`; combinational
- head_valid  out  1  queue non-empty
- head_pred  out  1  prediction of the oldest entry (drives checker `last_pred`)
- head_type  out  2  type of the oldest entry (drives checker `pred_type`)
- res_valid  in  1  checker resolved the oldest branch this cycle
- res_incorrect  in  1  checker `incorrect_pred`
- res_taken  in  1  actual outcome (checker `correct_pred`)
- flush  out  1  one-cycle squash pulse to fetch/decode
- redirect_valid  out  1  one-cycle pulse, same cycle as `flush`
- redirect_addr  out  11  corrected micro-PC
- underflow  out  1  sticky error: `res_valid` arrived while the queue was empty

## Operation
- **Predictor**
  - Counter index is `issue_pc[TBL_BITS-1:0]`.
  - All counters reset to 01 (weak not-taken). `pred_taken` = counter[1].
  - On an accepted resolution, the head's counter increments when `res_taken`=1 and decrements when `res_taken`=0. It saturates at 3 and 0.
  - The queue entry stores its index, so training never depends on the current `issue_pc`.
- **Queue**
  - FIFO with entry = {index, pc+1 (11-bit wrap), target, type, pred}. Occupancy counter is 0..DEPTH.
  - Push condition: `issue_valid & issue_ready & issue_type!=00`.
  - `issue_ready` = state RUN & (count<DEPTH | res_valid) & !(res_valid & res_incorrect).
- **Resolution**
  - If `res_valid` and count>0: pop the head and train its counter.
  - If `res_incorrect`=1 as well:
    - `redirect_addr` = `res_taken` ? head.target : head.pc+1.
    - Pulse `flush` and `redirect_valid`.
    - Clear the whole queue, count=0. A same-cycle issue is dropped.
    - Enter FLUSH.
  - If `res_valid` and count=0: set `underflow`. Nothing else changes.
- **FSM**
  - RUN: on a mispredict resolution, go to FLUSH and load `fcnt`=FLUSH_CYC-1.
  - FLUSH: `issue_ready`=0 and `res_valid` is ignored. Decrement `fcnt`; at 0, go to RUN.
- **Reset values**: state RUN, count 0, `head_valid` 0, `head_pred` 0, `head_type` 00, `flush` 0, `redirect_valid` 0, `redirect_addr` 0, `underflow` 0, all counters 01.
- **Reset mid-operation** discards the queue and any FLUSH countdown. The table is also reinitialised.

## Timing
- Prediction is zero latency. `pred_taken` is valid in the same cycle as `issue_pc`.
- A push is visible on `head_*` the next cycle when the queue was empty.
- Resolution to `flush`/`redirect_*` is one cycle; these outputs are registered.
- Training takes effect the cycle after resolution. A same-cycle issue to the same index sees the old counter.
- Full with simultaneous correct resolution and issue: pop and push both happen, and count is unchanged.
- Pointers wrap modulo DEPTH.
- After a redirect, `issue_ready` is first high FLUSH_CYC+1 cycles after the resolving edge: one cycle for the registered `flush`, then FLUSH_CYC cycles in FLUSH.

## Structure
- Shared package `ev20_branch_pkg`:
  - type codes TYPE_JZE=2'b01, TYPE_JNE=2'b10, TYPE_JCY=2'b11
  - counter reset value CNT_INIT=2'b01
  - FSM state encoding
  - queue-entry struct
- One sub-module, `pred_counter_table`: 2^TBL_BITS×2-bit saturating counters with async read and sync update. The controller holds the FIFO and the FSM.

## Test plan
- Reset, then issue pc=0x010, type JZE: `pred_taken`=0, `head_valid`=1 next cycle, `head_type`=01.
- Resolve that branch with `res_taken`=1 three times, re-issuing pc=0x010 each time: counter goes 01→10→11→11, and `pred_taken`=1 from the second issue on.
- Fill 4 entries: `issue_ready`=0. Then a correct resolve and an issue in the same cycle: count stays 4 and head advances.
- Head target=0x123, pc=0x040, `pred`=0; resolve with `res_incorrect`=1, `res_taken`=1: next cycle `flush`=1, `redirect_addr`=0x123, queue empty, `issue_ready` low for 2 further cycles.
- Head pc=0x7FF, predicted taken; resolve as not taken, incorrect: `redirect_addr`=0x000, showing the wrap.
- `res_valid` with an empty queue: `underflow`=1 and stays 1 until `rst_n`=0. Then drop `rst_n` mid-FLUSH: all outputs take their reset values the next cycle.
